// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// 1-bit full subtractor: d = a - b - br_in, with borrow out.
// Purely combinational (0 cycles); no flow control.
module sub_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a_i ^ b_i ^ br_in;
  assign br_out = (~a_i & b_i) | (~(a_i ^ b_i) & br_in);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor, LSB first; result valid WIDTH edges after accept.
// Accepts only in IDLE; holds q/borrow in DONE until out_ready, minimum period WIDTH+2.
module sub_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d;
  logic             br_q, br_d;
  logic             cell_d, cell_br;

  // Operands shift right so the current bit is always at position 0.
  sub_bit_cell u_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .br_in (br_q),
    .d     (cell_d),
    .br_out(cell_br)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign borrow    = br_q;
  assign cnt_inc   = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    br_d    = br_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        // Filling from the top lands the bit-i result at position i after WIDTH shifts.
        q_d   = {cell_d, q_q[WIDTH-1:1]};
        br_d  = cell_br;
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(WIDTH)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      br_q    <= br_d;
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: vector table plus hold, ignore and reset sequences.
module tb_sub_serial;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         borrow;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] eq;
    logic         eb;
  } vec_t;

  sub_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .borrow   (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for out_valid; returns edges elapsed since the accept edge.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] eq, input logic eb);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, int'(in_ready), 1);
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    chk({tag, " latency"}, lat, W);
    chk({tag, " q"}, int'(q), int'(eq));
    chk({tag, " borrow"}, int'(borrow), int'(eb));
    @(negedge clk);
    chk({tag, " out_valid drop"}, int'(out_valid), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   lat;
    logic [W-1:0] hq;
    logic         hb;

    vecs[0] = '{4'd5,  4'd3,  4'd2,  1'b0};
    vecs[1] = '{4'd3,  4'd5,  4'd14, 1'b1};
    vecs[2] = '{4'd0,  4'd1,  4'd15, 1'b1};
    vecs[3] = '{4'd9,  4'd9,  4'd0,  1'b0};
    vecs[4] = '{4'd15, 4'd0,  4'd15, 1'b0};
    vecs[5] = '{4'd8,  4'd15, 4'd9,  1'b1};
    vecs[6] = '{4'd10, 4'd4,  4'd6,  1'b0};
    vecs[7] = '{4'd0,  4'd15, 4'd1,  1'b1};

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    #1;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset q", int'(q), 0);
    chk("reset borrow", int'(borrow), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].eq, vecs[i].eb);
    end

    // Consumer stalls for 6 cycles in DONE.
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 4'd12;
    b         = 4'd7;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    chk("hold latency", lat, W);
    hq = q;
    hb = borrow;
    chk("hold q", int'(hq), 5);
    chk("hold borrow", int'(hb), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", i), int'(out_valid), 1);
      chk($sformatf("hold%0d in_ready", i), int'(in_ready), 0);
      chk($sformatf("hold%0d q", i), int'(q), 5);
      chk($sformatf("hold%0d borrow", i), int'(borrow), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold single transfer", int'(out_valid), 0);
    chk("hold back to idle", int'(in_ready), 1);
    @(negedge clk);
    chk("hold no second transfer", int'(out_valid), 0);

    // New operands and early out_ready during SHIFT must be ignored.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 4'd6;
    b         = 4'd1;
    @(negedge clk);
    lat = 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      in_valid = ~in_valid;
      a        = 4'(i + 11);
      b        = 4'(15 - i);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("ignore latency", lat, W);
    chk("ignore q", int'(q), 5);
    chk("ignore borrow", int'(borrow), 0);
    @(negedge clk);
    chk("ignore out_valid drop", int'(out_valid), 0);

    // Reset at the 2nd SHIFT edge aborts the operation.
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 4'd13;
    b         = 4'd6;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort q", int'(q), 0);
    chk("abort borrow", int'(borrow), 0);
    chk("abort out_valid", int'(out_valid), 0);
    chk("abort in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("abort no result", lat, 0);
    do_op("after reset", 4'd7, 4'd2, 4'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a and b are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: unsigned minuend.
REQ-007 SHALL have port b, input, WIDTH bits: unsigned subtrahend.
REQ-008 SHALL have port out_valid, output, 1 bit: q and borrow are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port q, output, WIDTH bits: (a - b) mod 2^WIDTH.
REQ-011 SHALL have port borrow, output, 1 bit: 1 when a < b, unsigned.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; in_ready is a decode of the state register, with no combinational path from in_valid.
REQ-014 SHALL accept operands on an edge where in_valid && in_ready: capture a and b, clear the borrow register and bit counter, and go IDLE -> SHIFT.
REQ-015 SHALL in SHIFT process one bit per edge, LSB first, with a full-subtractor cell: d = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 SHALL shift each d into the result register at bit position i.
REQ-017 SHALL, on the WIDTH-th SHIFT edge, go SHIFT -> DONE with borrow = final br; out_valid therefore rises exactly WIDTH edges after the accepting edge.
REQ-018 SHALL in DONE hold out_valid = 1 and keep q and borrow stable until out_valid && out_ready.
REQ-019 SHALL on that output handshake go DONE -> IDLE; out_valid drops on the same edge.
REQ-020 SHALL ignore in_valid, a and b outside IDLE; operands are never re-sampled mid-operation.
REQ-021 SHALL give a back-to-back minimum period of WIDTH+2 edges: accept, WIDTH shift edges, output handshake edge, return to IDLE.
REQ-022 SHALL hold q and borrow at their last values after the output handshake; they are don't-care to the consumer while out_valid = 0.
REQ-023 SHALL size the bit counter as ceil(log2(WIDTH+1)) bits and compare it exactly against WIDTH, with no wrap-around.
REQ-024 SHALL treat an out_ready asserted before DONE as having no effect.

Reset
REQ-025 SHALL, while rst_n = 0, force state = IDLE, out_valid = 0, q = 0, borrow = 0, counter = 0 and the operand registers = 0, immediately and without waiting for clk.
REQ-026 SHALL, when reset is asserted mid-SHIFT or mid-DONE, discard the operation with no result emitted; after rst_n rises, in_ready = 1.

Structure
REQ-027 SHALL place the state enumeration (IDLE, SHIFT, DONE) and the default-width constant in shared package sub_pkg.
REQ-028 SHALL instantiate one sub-module, sub_bit_cell: a combinational 1-bit full subtractor with inputs a_i, b_i, br_in and outputs d, br_out.
REQ-029 SHALL use no multi-bit arithmetic operator in the datapath; the subtraction is built entirely from sub_bit_cell.

Verification
REQ-030 SHALL cover: a=5, b=3, out_ready=1 -> q=2, borrow=0, out_valid high 4 edges after accept.
REQ-031 SHALL cover: a=3, b=5 -> q=14, borrow=1; and a=0, b=1 -> q=15, borrow=1.
REQ-032 SHALL cover: a=9, b=9 -> q=0, borrow=0; and a=15, b=0 -> q=15, borrow=0.
REQ-033 SHALL cover: out_ready=0 for 6 cycles in DONE -> q, borrow and out_valid held stable, in_ready=0 throughout, and a single transfer when out_ready rises.
REQ-034 SHALL cover: in_valid toggled with new operands during SHIFT -> ignored, result still matches the first operands.
REQ-035 SHALL cover: rst_n pulsed low at the 2nd SHIFT edge -> outputs zero immediately, no out_valid, and the next operation 7 - 2 -> q=5, borrow=0.
